// File: rtl/regfile_rename_if.sv
// Bus between the issue/commit/dispatch logic and the renamed register file.
// The master side drives rename, commit and read requests; the slave side
// is the register file, which returns the per-port read results.
interface regfile_rename_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int TAG_W  = 4,
  parameter int NRD    = 2
);
  logic                  rdy;
  logic                  flush;
  logic                  rename_valid;
  logic [REG_AW-1:0]     rename_addr;
  logic [TAG_W-1:0]      rename_tag;
  logic                  commit_valid;
  logic [REG_AW-1:0]     commit_addr;
  logic [TAG_W-1:0]      commit_tag;
  logic [XLEN-1:0]       commit_data;
  logic [NRD-1:0]        rd_en;
  logic [NRD*REG_AW-1:0] rd_addr;
  logic [NRD-1:0]        rd_valid;
  logic [NRD-1:0]        rd_busy;
  logic [NRD*TAG_W-1:0]  rd_tag;
  logic [NRD*XLEN-1:0]   rd_data;

  modport master (
    output rdy, flush,
    output rename_valid, rename_addr, rename_tag,
    output commit_valid, commit_addr, commit_tag, commit_data,
    output rd_en, rd_addr,
    input  rd_valid, rd_busy, rd_tag, rd_data
  );

  modport slave (
    input  rdy, flush,
    input  rename_valid, rename_addr, rename_tag,
    input  commit_valid, commit_addr, commit_tag, commit_data,
    input  rd_en, rd_addr,
    output rd_valid, rd_busy, rd_tag, rd_data
  );
endinterface

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags and busy bits.
// Issue renames a destination to a ROB tag; commit writes the value and
// clears busy only when the committing tag is still the latest rename.
// Read ports are combinational and bypass a matching same-cycle commit.
module regfile_rename #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int TAG_W  = 4,
  parameter int NRD    = 2
) (
  input logic             clk,
  input logic             rst,
  regfile_rename_if.slave bus
);
  localparam int NREG = 2 ** REG_AW;

  logic [XLEN-1:0]  regs [NREG];
  logic [TAG_W-1:0] tags [NREG];
  logic [NREG-1:0]  busy;

  // Commit then rename/flush; later assignments to busy win, so a rename or
  // flush overrides a commit to the same register in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        tags[r] <= '0;
      end
      busy <= '0;
    end else if (bus.rdy) begin
      if (bus.commit_valid && bus.commit_addr != '0) begin
        regs[bus.commit_addr] <= bus.commit_data;
        if (busy[bus.commit_addr] && tags[bus.commit_addr] == bus.commit_tag)
          busy[bus.commit_addr] <= 1'b0;
      end
      if (bus.flush) begin
        busy <= '0;
      end else if (bus.rename_valid && bus.rename_addr != '0) begin
        busy[bus.rename_addr] <= 1'b1;
        tags[bus.rename_addr] <= bus.rename_tag;
      end
    end
  end

  // Per-port read resolution on pre-edge state, forced to zero during reset.
  always_comb begin
    logic [REG_AW-1:0] addr;
    addr         = '0;
    bus.rd_valid = '0;
    bus.rd_busy  = '0;
    bus.rd_tag   = '0;
    bus.rd_data  = '0;
    if (!rst) begin
      for (int i = 0; i < NRD; i++) begin
        addr = bus.rd_addr[i*REG_AW +: REG_AW];
        if (bus.rd_en[i]) begin
          bus.rd_valid[i] = 1'b1;
          if (addr == '0) begin
            bus.rd_data[i*XLEN +: XLEN] = '0;
          end else if (busy[addr] && bus.commit_valid &&
                       bus.commit_addr == addr && bus.commit_tag == tags[addr]) begin
            bus.rd_data[i*XLEN +: XLEN] = bus.commit_data;
          end else begin
            bus.rd_busy[i]               = busy[addr];
            bus.rd_tag[i*TAG_W +: TAG_W] = tags[addr];
            bus.rd_data[i*XLEN +: XLEN]  = regs[addr];
          end
        end
      end
    end
  end
endmodule
